// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares one WIDTH-bit adder between NUM_REQ requesters. Requests are granted
// round-robin, each grant produces one registered sum plus carry-out, and the
// result is held on a valid/ready output until the downstream accepts it.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         res_valid,
    output logic [WIDTH-1:0]             res_data,
    output logic                         res_carry,
    output logic [$clog2(NUM_REQ)-1:0]   res_id,
    input  logic                         res_ready,
    output logic                         busy,
    output logic [7:0]                   op_count
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [IDW-1:0] ID_ONE = IDW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand_idx;
    logic             grant_found;
    logic             grant_fire;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   g_q;
    logic [WIDTH:0]   sum_full;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = rr_ptr + IDW'(k);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Next-state and grant decode; reset suppresses any grant in its cycle.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        grant_fire = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    grant_fire           = 1'b1;
                    state_next           = EXEC;
                end
            end
            EXEC: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Full-width sum so the carry-out falls out as the top bit.
    always_comb begin
        sum_full = {1'b0, a_q} + {1'b0, b_q};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, result register, round-robin pointer and op counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            op_count  <= 8'd0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            g_q       <= '0;
        end else begin
            if (grant_fire) begin
                a_q    <= req_a[grant_idx*WIDTH +: WIDTH];
                b_q    <= req_b[grant_idx*WIDTH +: WIDTH];
                g_q    <= grant_idx;
                rr_ptr <= grant_idx + ID_ONE;
            end
            if (state == EXEC) begin
                {res_carry, res_data} <= sum_full;
                res_id                <= g_q;
                res_valid             <= 1'b1;
            end
            if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
